// File: rtl/hilo_unit_if.sv
// Execute-stage bus between the pipeline/multiplier and the HI/LO unit.
// master drives the request side; slave is the hilo_unit itself.
interface hilo_unit_if;
   logic        flush;
   logic        start;
   logic [63:0] product;
   logic [1:0]  acc_op;
   logic        we_hi;
   logic        we_lo;
   logic [31:0] wdata;
   logic        rd_hilo;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy;
   logic        stall_req;

   modport master (
      output flush, start, product, acc_op, we_hi, we_lo, wdata, rd_hilo,
      input  hi_o, lo_o, busy, stall_req
   );

   modport slave (
      input  flush, start, product, acc_op, we_hi, we_lo, wdata, rd_hilo,
      output hi_o, lo_o, busy, stall_req
   );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: retimes the multiplier product over MULT_LAT (1..4) cycles, then commits it.
// Define HILO_ACC_EN to enable multiply-accumulate (add/sub) on commit.
module hilo_unit #(
   parameter int unsigned MULT_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   hilo_unit_if.slave bus
);

   typedef enum logic {StIdle, StRun} state_e;

   state_e      state_q;
   logic        busy_q;
   logic [1:0]  cnt_q;
   logic [63:0] stage_q [MULT_LAT];
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [63:0] commit_val;
   logic        stall_req;
   logic        accept;
   logic        last;

`ifdef HILO_ACC_EN
   logic [1:0]  acc_q;
`else
   logic        unused_acc_op;
   assign unused_acc_op = ^bus.acc_op;
`endif

   // Any instruction touching HI/LO (or a second multiply) must wait out the in-flight one.
   assign stall_req = busy_q & (bus.rd_hilo | bus.start | bus.we_hi | bus.we_lo);
   assign accept    = (state_q == StIdle) & bus.start & ~bus.flush & ~stall_req;
   assign last      = (cnt_q == 2'(MULT_LAT - 1));

   always_comb begin
      commit_val = stage_q[MULT_LAT-1];
`ifdef HILO_ACC_EN
      case (acc_q)
         2'b01:   commit_val = {hi_q, lo_q} + stage_q[MULT_LAT-1];
         2'b10:   commit_val = {hi_q, lo_q} - stage_q[MULT_LAT-1];
         default: commit_val = stage_q[MULT_LAT-1];
      endcase
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         cnt_q   <= 2'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         for (int i = 0; i < MULT_LAT; i++) begin
            stage_q[i] <= 64'd0;
         end
`ifdef HILO_ACC_EN
         acc_q   <= 2'b00;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               // Flush kills both the MT write and the multiply issue.
               if (!bus.flush) begin
                  if (bus.we_hi) hi_q <= bus.wdata;
                  if (bus.we_lo) lo_q <= bus.wdata;
               end
               if (accept) begin
                  state_q    <= StRun;
                  busy_q     <= 1'b1;
                  cnt_q      <= 2'd0;
                  stage_q[0] <= bus.product;
`ifdef HILO_ACC_EN
                  acc_q      <= bus.acc_op;
`endif
               end
            end
            StRun: begin
               if (bus.flush) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  cnt_q   <= 2'd0;
               end else if (last) begin
                  {hi_q, lo_q} <= commit_val;
                  state_q      <= StIdle;
                  busy_q       <= 1'b0;
                  cnt_q        <= 2'd0;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
                  for (int i = 1; i < MULT_LAT; i++) begin
                     stage_q[i] <= stage_q[i-1];
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hi_o      = hi_q;
   assign bus.lo_o      = lo_q;
   assign bus.busy      = busy_q;
   assign bus.stall_req = stall_req;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: vector table, commit scoreboard and hand-written corner cases.
module tb_hilo_unit;
   localparam int unsigned LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hilo_unit_if bus ();

   hilo_unit #(.MULT_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          is_mt;
      bit          hi_sel;
      logic [63:0] product;
      logic [1:0]  acc;
      logic [31:0] wdata;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t        vecs [6];
   logic [63:0] exp_q [$];
   int          n_checks = 0;
   int          n_err    = 0;
   logic        prev_busy = 1'b0;
   logic [63:0] model;
   logic [63:0] acc_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every busy 1->0 transition must land on the queued HI/LO value.
   always @(negedge clk) begin
      if (prev_busy && !bus.busy && !rst) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_commit: got %h%h expected none", bus.hi_o, bus.lo_o);
         end else begin
            check("commit_hilo", {bus.hi_o, bus.lo_o}, exp_q.pop_front());
         end
      end
      prev_busy = bus.busy;
   end

   task automatic do_mult(input logic [63:0] p, input logic [1:0] acc, input logic [63:0] exp);
      exp_q.push_back(exp);
      bus.start   = 1'b1;
      bus.product = p;
      bus.acc_op  = acc;
      step();
      bus.start   = 1'b0;
      bus.acc_op  = 2'b00;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         check("busy_run", bus.busy, 1);
         step();
      end
      @(negedge clk);
      check("busy_done", bus.busy, 0);
      model = exp;
   endtask

   task automatic do_mt(input bit hi_sel, input logic [31:0] d,
                        input logic [31:0] eh, input logic [31:0] el);
      bus.we_hi = hi_sel;
      bus.we_lo = !hi_sel;
      bus.wdata = d;
      step();
      bus.we_hi = 1'b0;
      bus.we_lo = 1'b0;
      @(negedge clk);
      check("mt_hi", bus.hi_o, eh);
      check("mt_lo", bus.lo_o, el);
      model = {eh, el};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFA, 2'b00, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{1'b1, 1'b0, 64'h0, 2'b00, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
      vecs[2] = '{1'b1, 1'b1, 64'h0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678};
      vecs[3] = '{1'b0, 1'b0, 64'h00000001_00000002, 2'b11, 32'h0, 32'h00000001, 32'h00000002};
      vecs[4] = '{1'b0, 1'b0, 64'h0, 2'b00, 32'h0, 32'h0, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 64'h0, 2'b00, 32'h5, 32'h0, 32'h5};

      bus.flush = 1'b0; bus.start = 1'b1; bus.product = 64'hFFFF; bus.acc_op = 2'b00;
      bus.we_hi = 1'b0; bus.we_lo = 1'b0; bus.wdata = 32'h0; bus.rd_hilo = 1'b1;
      #3;
      check("rst_hi", bus.hi_o, 0);
      check("rst_lo", bus.lo_o, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_stall", bus.stall_req, 0);
      step();
      bus.start = 1'b0; bus.rd_hilo = 1'b0;
      rst = 1'b0;
      step();
      model = 64'd0;

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].is_mt) do_mt(vecs[i].hi_sel, vecs[i].wdata, vecs[i].exp_hi, vecs[i].exp_lo);
         else do_mult(vecs[i].product, vecs[i].acc, {vecs[i].exp_hi, vecs[i].exp_lo});
      end

      // MFHI right behind a multiply stalls until the result is visible.
      exp_q.push_back(64'h00000003_80000001);
      bus.start = 1'b1; bus.product = 64'h00000003_80000001;
      step();
      bus.start = 1'b0; bus.rd_hilo = 1'b1;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         check("stall_rd", bus.stall_req, 1);
         step();
      end
      @(negedge clk);
      check("stall_rd_clear", bus.stall_req, 0);
      check("busy_rd_clear", bus.busy, 0);
      bus.rd_hilo = 1'b0;
      model = 64'h00000003_80000001;

      // MTHI and a second start while busy: stalled, neither takes effect.
      exp_q.push_back(64'hCAFE0000_0000BABE);
      bus.start = 1'b1; bus.product = 64'hCAFE0000_0000BABE;
      step();
      bus.product = 64'h11111111_11111111; bus.we_hi = 1'b1; bus.wdata = 32'hAAAAAAAA;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         check("stall_we_busy", bus.stall_req, 1);
         step();
      end
      bus.start = 1'b0; bus.we_hi = 1'b0;
      @(negedge clk);
      check("busy_we_clear", bus.busy, 0);
      step();
      @(negedge clk);
      check("no_capture_busy", bus.busy, 0);
      check("no_write_busy", {bus.hi_o, bus.lo_o}, 64'hCAFE0000_0000BABE);
      model = 64'hCAFE0000_0000BABE;

      // Flush one cycle after start: no commit.
      exp_q.push_back(64'h1);
      bus.start = 1'b1; bus.product = 64'h1;
      step();
      bus.start = 1'b0; bus.flush = 1'b1;
      exp_q[0] = model;
      step();
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_busy", bus.busy, 0);

      // Flush exactly on the commit cycle.
      exp_q.push_back(64'h2222);
      bus.start = 1'b1; bus.product = 64'h2222;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < LAT - 1; k++) step();
      bus.flush = 1'b1;
      exp_q[0] = model;
      step();
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_commit_busy", bus.busy, 0);

      // Flush in idle suppresses a same-cycle start and MTLO.
      bus.flush = 1'b1; bus.start = 1'b1; bus.we_lo = 1'b1; bus.wdata = 32'hFFFF0000;
      bus.product = 64'h3333;
      step();
      bus.flush = 1'b0; bus.start = 1'b0; bus.we_lo = 1'b0;
      @(negedge clk);
      check("flush_idle_busy", bus.busy, 0);
      check("flush_idle_hilo", {bus.hi_o, bus.lo_o}, model);

      // Start plus MTHI together in idle: write lands now, product overwrites later.
      exp_q.push_back(64'h00000009_00000008);
      bus.start = 1'b1; bus.product = 64'h00000009_00000008;
      bus.we_hi = 1'b1; bus.wdata = 32'h55555555;
      step();
      bus.start = 1'b0; bus.we_hi = 1'b0;
      @(negedge clk);
      check("mt_with_start_hi", bus.hi_o, 32'h55555555);
      check("mt_with_start_lo", bus.lo_o, model[31:0]);
      check("mt_with_start_busy", bus.busy, 1);
      for (int k = 0; k < LAT; k++) step();
      @(negedge clk);
      check("mt_with_start_done", bus.busy, 0);
      model = 64'h00000009_00000008;

      // Asynchronous reset between edges during RUN.
      bus.start = 1'b1; bus.product = 64'h44444444_44444444;
      step();
      bus.start = 1'b0;
      #1;
      rst = 1'b1; bus.rd_hilo = 1'b1;
      #1;
      check("arst_hi", bus.hi_o, 0);
      check("arst_lo", bus.lo_o, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_stall", bus.stall_req, 0);
      exp_q.delete();
      rst = 1'b0; bus.rd_hilo = 1'b0;
      step();
      model = 64'd0;

      // Accumulate (plain load without HILO_ACC_EN); subtract then wrapping add.
      do_mt(1'b0, 32'h5, 32'h0, 32'h5);
`ifdef HILO_ACC_EN
      acc_exp = 64'hFFFFFFFF_FFFFFFFE;
`else
      acc_exp = 64'h7;
`endif
      do_mult(64'h7, 2'b10, acc_exp);
`ifdef HILO_ACC_EN
      acc_exp = 64'h1;
`else
      acc_exp = 64'h3;
`endif
      do_mult(64'h3, 2'b01, acc_exp);

      step();
      step();
      check("sb_drained", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Downstream consumer of the combinational 32x32 multiplier in the execute stage.
- Registers the 64-bit product through a MULT_LAT-cycle retiming pipeline, breaking the long multiply path, then commits it to the architectural HI/LO registers.
- Also handles MTHI/MTLO writes, MFHI/MFLO read hazards and pipeline flush.
- Raises a stall request toward the hazard unit while a multiply is in flight.

Parameters:
- MULT_LAT, 2, cycles from start to HI/LO commit; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  cancels any in-flight multiply (exception/branch flush).
- start  input  1  multiply issue; product is valid in the same cycle.
- product  input  64  multiplier output y, {hi,lo}.
- acc_op  input  2  00 plain, 01 accumulate-add, 10 accumulate-sub, 11 treated as 00 (used only with HILO_ACC_EN).
- we_hi  input  1  MTHI write enable.
- we_lo  input  1  MTLO write enable.
- wdata  input  32  MTHI/MTLO data.
- rd_hilo  input  1  an MFHI/MFLO is in execute this cycle.
- hi_o  output  32  architectural HI.
- lo_o  output  32  architectural LO.
- busy  output  1  a multiply is in flight.
- stall_req  output  1  the pipeline must hold the current instruction.

Behaviour:
- Reset is asynchronous. All of the following clear to 0 immediately on rst: hi_o, lo_o, busy, the product pipeline, the stored acc_op and the internal counter. stall_req is combinational and therefore 0 while rst is held.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, counter cnt counts 0..MULT_LAT-1.
- IDLE -> RUN on start & ~flush & ~stall_req. On that edge, product and acc_op are captured into stage 0 and cnt=0.
- RUN: cnt increments each cycle and data advances one stage. When cnt==MULT_LAT-1, the next edge commits {hi_o,lo_o} <= final stage and returns to IDLE.
- Timing: start at edge N; busy is high for edges N+1..N+MULT_LAT; the new HI/LO is visible after edge N+MULT_LAT.
- stall_req = busy & (rd_hilo | start | we_hi | we_lo). This covers read-after-multiply and structural conflicts.
  - The stalled instruction is re-presented by the pipeline.
  - A start that arrives while busy is ignored (no capture).
- MTHI/MTLO in IDLE: the selected register <= wdata on the next edge; the other register is unchanged.
- Simultaneous start and we_hi/we_lo in IDLE: the MT write commits next edge; the multiply is also captured and its later commit overwrites both registers.
- flush has priority over everything except rst.
  - In RUN: the next edge returns to IDLE, busy=0, and no commit occurs; HI/LO keep their pre-start values.
  - flush on the commit cycle also suppresses the commit.
  - flush in IDLE also suppresses a same-cycle start and MT write.
- Reset asserted mid-operation abandons the operation; HI/LO read 0.
- No combinational path from product to hi_o/lo_o. Outputs are registered.

Optional Feature:
- HILO_ACC_EN defined: on commit, a captured acc_op of 01 gives {hi,lo} <= {hi,lo} + stage_product, and 10 gives {hi,lo} <= {hi,lo} - stage_product. The arithmetic is 64-bit modulo 2^64, uses the HI/LO values at commit time, and discards the carry/borrow.
- HILO_ACC_EN undefined: acc_op is ignored, is not stored, and every commit is a plain load.

Test Plan:
- Reset then MULT_LAT=2, start with product=64'hFFFFFFFF_FFFFFFFA (signed 3*-2) -> busy high for 2 cycles; hi_o=FFFFFFFF, lo_o=FFFFFFFA after the 2nd edge; busy=0.
- start, then rd_hilo=1 on the next cycle -> stall_req=1 for exactly 2 cycles (MULT_LAT=2), then 0 in the cycle the new values are visible.
- we_lo=1, wdata=32'h1234_5678 in IDLE -> lo_o=12345678 next edge, hi_o unchanged; repeat with we_hi=1 while busy -> stall_req=1 and no write.
- start with product=64'h1, flush asserted 1 cycle later -> busy=0 next edge; HI/LO keep prior values (e.g. 0/0).
- Asynchronous rst pulse between edges during RUN -> hi_o, lo_o and busy read 0 immediately; a later start works normally.
- With HILO_ACC_EN, HI/LO=0/5, start acc_op=10, product=64'h7 -> {hi,lo}=64'hFFFFFFFF_FFFFFFFE. Without the macro -> {hi,lo}=0/7.
